// File: rtl/rgmii_phy_speed_ctrl_pkg.sv
// Shared types and constants for the RGMII PHY speed controller:
// MDIO frame fields, status-register bit positions and the status decoder.
package rgmii_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4
    } mdio_state_t;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FRAME = 2'd1,
        S_EVAL  = 2'd2,
        S_HOLD  = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] MDIO_START   = 2'b01;
    localparam logic [1:0] MDIO_OP_READ = 2'b10;
    localparam logic [1:0] SPEED_10     = 2'b00;
    localparam logic [1:0] SPEED_100    = 2'b01;

    localparam int LINK_BIT     = 10;
    localparam int RESOLVED_BIT = 11;
    localparam int SPEED_MSB    = 15;

    // Debounce candidate: link usable by the adapter plus the raw speed field.
    typedef struct packed {
        logic       ok;
        logic [1:0] spd;
    } status_t;

    localparam status_t RESET_CAND = '{ok: 1'b0, spd: SPEED_100};

    // 1000M and the reserved speed code cannot be carried by the adapter,
    // so they decode as link down.
    function automatic status_t decode_status(input logic [15:0] word);
        status_t st;
        st.spd = word[SPEED_MSB -: 2];
        st.ok  = word[LINK_BIT] & word[RESOLVED_BIT] &
                 ((st.spd == SPEED_10) | (st.spd == SPEED_100));
        return st;
    endfunction

endpackage

// File: rtl/rgmii_phy_speed_ctrl_if.sv
// MDIO management bus between the speed controller (master) and the PHY pad (slave).
interface rgmii_phy_speed_ctrl_if;
    logic mdc;
    logic mdio_o;
    logic mdio_oe;
    logic mdio_i;

    modport master (output mdc, output mdio_o, output mdio_oe, input mdio_i);
    modport slave  (input mdc, input mdio_o, input mdio_oe, output mdio_i);
endinterface

// File: rtl/rgmii_phy_speed_ctrl_mdio_read_engine.sv
// Clause-22 MDIO read engine: MDC divider, header shifter and bit-level FSM.
// A start pulse in S_IDLE launches one read; done pulses with data valid.
module mdio_read_engine
    import rgmii_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 10,
    parameter logic [4:0]  PHY_ADDR   = 5'd0,
    parameter logic [4:0]  STATUS_REG = 5'h11
) (
    input  logic                          clk,
    input  logic                          rst,
    rgmii_phy_speed_ctrl_if.master        mdio,
    input  logic                          start,
    output logic                          done,
    output logic [15:0]                   data
);

    localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [13:0]      HDR      = {MDIO_START, MDIO_OP_READ, PHY_ADDR, STATUS_REG};

    mdio_state_t      state_r, state_s;
    logic [DIV_W-1:0] div_r;
    logic [5:0]       bit_cnt_r;
    logic [13:0]      hdr_sr_r;
    logic [15:0]      rx_sr_r, data_r;
    logic             mdc_r, mdio_o_r, mdio_oe_r, done_r;
    logic             tick_s, fall_s, rise_s, last_bit_s;

    assign mdio.mdc     = mdc_r;
    assign mdio.mdio_o  = mdio_o_r;
    assign mdio.mdio_oe = mdio_oe_r;
    assign done         = done_r;
    assign data         = data_r;

    // MDC edge events and the last bit of the current frame phase.
    always_comb begin
        tick_s = (state_r != S_IDLE) && (div_r == DIV_LAST);
        fall_s = tick_s & mdc_r;
        rise_s = tick_s & ~mdc_r;
        case (state_r)
            S_PRE:   last_bit_s = (bit_cnt_r == 6'd31);
            S_HDR:   last_bit_s = (bit_cnt_r == 6'd13);
            S_TA:    last_bit_s = (bit_cnt_r == 6'd1);
            S_DATA:  last_bit_s = (bit_cnt_r == 6'd15);
            default: last_bit_s = 1'b0;
        endcase
    end

    // Bit FSM next state: phases advance on the fall event ending their last bit.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: if (start) state_s = S_PRE; else state_s = S_IDLE;
            S_PRE:  if (fall_s && last_bit_s) state_s = S_HDR;  else state_s = S_PRE;
            S_HDR:  if (fall_s && last_bit_s) state_s = S_TA;   else state_s = S_HDR;
            S_TA:   if (fall_s && last_bit_s) state_s = S_DATA; else state_s = S_TA;
            S_DATA: if (fall_s && last_bit_s) state_s = S_IDLE; else state_s = S_DATA;
            default: state_s = S_IDLE;
        endcase
    end

    // Bit FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_s;
    end

    // Divider, MDIO output bits (changed on fall events) and data capture (on rise events).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r     <= '0;
            bit_cnt_r <= 6'd0;
            hdr_sr_r  <= 14'd0;
            rx_sr_r   <= 16'd0;
            data_r    <= 16'd0;
            mdc_r     <= 1'b0;
            mdio_o_r  <= 1'b1;
            mdio_oe_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    div_r     <= '0;
                    mdc_r     <= 1'b0;
                    bit_cnt_r <= 6'd0;
                    if (start) begin
                        mdio_oe_r <= 1'b1;
                        mdio_o_r  <= 1'b1;
                        hdr_sr_r  <= HDR;
                    end
                end
                default: begin
                    if (tick_s) begin
                        div_r <= '0;
                        mdc_r <= ~mdc_r;
                    end else begin
                        div_r <= div_r + DIV_ONE;
                    end
                    if (rise_s && (state_r == S_DATA)) begin
                        rx_sr_r <= {rx_sr_r[14:0], mdio.mdio_i};
                    end
                    if (fall_s) begin
                        if (last_bit_s) bit_cnt_r <= 6'd0;
                        else            bit_cnt_r <= bit_cnt_r + 6'd1;
                        case (state_r)
                            S_PRE: begin
                                if (last_bit_s) mdio_o_r <= hdr_sr_r[13];
                            end
                            S_HDR: begin
                                if (last_bit_s) begin
                                    mdio_oe_r <= 1'b0;
                                    mdio_o_r  <= 1'b1;
                                end else begin
                                    hdr_sr_r <= {hdr_sr_r[12:0], 1'b0};
                                    mdio_o_r <= hdr_sr_r[12];
                                end
                            end
                            S_DATA: begin
                                if (last_bit_s) begin
                                    done_r <= 1'b1;
                                    data_r <= rx_sr_r;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/rgmii_phy_speed_ctrl.sv
// Polls the PHY status register over MDIO, debounces link/speed across two
// polls and reconfigures the MII-to-RGMII adapter, holding it in reset
// for RESET_HOLD cycles on every accepted change.
module rgmii_phy_speed_ctrl
    import rgmii_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 10,
    parameter logic [4:0]  PHY_ADDR      = 5'd0,
    parameter logic [4:0]  STATUS_REG    = 5'h11,
    parameter int unsigned POLL_INTERVAL = 1000000,
    parameter int unsigned RESET_HOLD    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    rgmii_phy_speed_ctrl_if.master mdio,
    output logic                   eth_10mbps,
    output logic                   adapter_rst,
    output logic                   link_up,
    output logic [1:0]             speed,
    output logic                   poll_done
);

    localparam int unsigned      IVL_W     = $clog2(POLL_INTERVAL + 1);
    localparam logic [IVL_W-1:0] IVL_LAST  = IVL_W'(POLL_INTERVAL - 1);
    localparam logic [IVL_W-1:0] IVL_ONE   = IVL_W'(1);
    localparam int unsigned      HOLD_W    = $clog2(RESET_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    ctrl_state_t       state_r, state_s;
    logic [IVL_W-1:0]  ivl_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    status_t           cand_r, cand_s;
    logic              first_poll_r, first_hold_r;
    logic              eth_10mbps_r, adapter_rst_r, link_up_r, poll_done_r;
    logic [1:0]        speed_r;
    logic              start_s, eng_done_s, match_s, change_s, take_hold_s;
    logic [15:0]       eng_data_s;

    mdio_read_engine #(
        .CLK_DIV    (CLK_DIV),
        .PHY_ADDR   (PHY_ADDR),
        .STATUS_REG (STATUS_REG)
    ) u_engine (
        .clk   (clk),
        .rst   (rst),
        .mdio  (mdio),
        .start (start_s),
        .done  (eng_done_s),
        .data  (eng_data_s)
    );

    assign eth_10mbps  = eth_10mbps_r;
    assign adapter_rst = adapter_rst_r;
    assign link_up     = link_up_r;
    assign speed       = speed_r;
    assign poll_done   = poll_done_r;

    // Decode the captured status word and decide whether it is accepted and changes anything.
    always_comb begin
        cand_s      = decode_status(eng_data_s);
        match_s     = (cand_s == cand_r);
        change_s    = (cand_s.ok != link_up_r) | (cand_s.ok & (cand_s.spd != speed_r));
        take_hold_s = match_s & (change_s | first_hold_r);
    end

    // Poll sequencer next state and engine start.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            S_WAIT: begin
                if (first_poll_r || (ivl_cnt_r == IVL_LAST)) begin
                    start_s = 1'b1;
                    state_s = S_FRAME;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_FRAME: if (eng_done_s) state_s = S_EVAL; else state_s = S_FRAME;
            S_EVAL:  if (take_hold_s) state_s = S_HOLD; else state_s = S_WAIT;
            S_HOLD:  if (hold_cnt_r == HOLD_LAST) state_s = S_WAIT; else state_s = S_HOLD;
            default: state_s = S_WAIT;
        endcase
    end

    // Poll sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_WAIT;
        else     state_r <= state_s;
    end

    // Interval/hold timers, debounce history and the adapter-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ivl_cnt_r     <= '0;
            hold_cnt_r    <= '0;
            cand_r        <= RESET_CAND;
            first_poll_r  <= 1'b1;
            first_hold_r  <= 1'b1;
            eth_10mbps_r  <= 1'b0;
            adapter_rst_r <= 1'b1;
            link_up_r     <= 1'b0;
            speed_r       <= SPEED_100;
            poll_done_r   <= 1'b0;
        end else begin
            poll_done_r <= (state_r == S_FRAME) && eng_done_s;
            case (state_r)
                S_WAIT: begin
                    if (state_s == S_FRAME) begin
                        ivl_cnt_r    <= '0;
                        first_poll_r <= 1'b0;
                    end else begin
                        ivl_cnt_r <= ivl_cnt_r + IVL_ONE;
                    end
                end
                S_EVAL: begin
                    ivl_cnt_r <= '0;
                    cand_r    <= cand_s;
                    if (take_hold_s) begin
                        hold_cnt_r    <= '0;
                        adapter_rst_r <= 1'b1;
                        link_up_r     <= cand_s.ok;
                        if (cand_s.ok) begin
                            speed_r      <= cand_s.spd;
                            eth_10mbps_r <= (cand_s.spd == SPEED_10);
                        end
                    end
                end
                S_HOLD: begin
                    ivl_cnt_r <= '0;
                    if (hold_cnt_r == HOLD_LAST) begin
                        adapter_rst_r <= 1'b0;
                        first_hold_r  <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                    end
                end
                default: ivl_cnt_r <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_phy_speed_ctrl.sv
// Bench for rgmii_phy_speed_ctrl: a behavioural PHY answers each MDIO read
// with phy_data; a table of per-poll responses and expected adapter
// configuration drives the main checks, with hand sequences for frame
// format and asynchronous reset mid-frame.
module tb_rgmii_phy_speed_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       eth_10mbps, adapter_rst, link_up, poll_done;
    logic [1:0] speed;

    rgmii_phy_speed_ctrl_if mdio_bus ();

    rgmii_phy_speed_ctrl #(
        .CLK_DIV       (2),
        .PHY_ADDR      (5'd3),
        .STATUS_REG    (5'h11),
        .POLL_INTERVAL (200),
        .RESET_HOLD    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mdio        (mdio_bus),
        .eth_10mbps  (eth_10mbps),
        .adapter_rst (adapter_rst),
        .link_up     (link_up),
        .speed       (speed),
        .poll_done   (poll_done)
    );

    always #5 clk = ~clk;

    // PHY model state
    logic [15:0] phy_data;
    logic [63:0] tx_bits = 64'd0;
    logic        mdc_q = 1'b0, oe_q = 1'b0;
    int          tx_cnt = 0, rx_rise = 0, cyc = 0, last_rise_cyc = 0, mdc_period = 0, o_viol = 0;

    // PHY model: records what the controller drives, answers with phy_data after turnaround.
    always @(negedge clk) begin
        cyc++;
        if (rst === 1'b1) begin
            mdio_bus.mdio_i = 1'b1;
        end
        if (mdio_bus.mdio_oe && !oe_q) begin
            tx_cnt = 0; rx_rise = 0; tx_bits = 64'd0; last_rise_cyc = 0;
            mdio_bus.mdio_i = 1'b1;
        end
        if (mdio_bus.mdc && !mdc_q) begin
            if (last_rise_cyc != 0) mdc_period = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
            if (mdio_bus.mdio_oe) begin
                tx_bits = {tx_bits[62:0], mdio_bus.mdio_o};
                tx_cnt++;
            end else begin
                rx_rise++;
            end
        end
        if (!mdio_bus.mdc && mdc_q) begin
            if (!mdio_bus.mdio_oe && rx_rise >= 2 && rx_rise < 18)
                mdio_bus.mdio_i = phy_data[15 - (rx_rise - 2)];
            else
                mdio_bus.mdio_i = 1'b1;
        end
        if (rst === 1'b0 && !mdio_bus.mdio_oe && !mdio_bus.mdio_o) o_viol++;
        mdc_q = mdio_bus.mdc;
        oe_q  = mdio_bus.mdio_oe;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_poll(input int budget);
        int n;
        n = 0;
        while (poll_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (poll_done !== 1'b1) begin
            errors++;
            $display("FAIL poll_timeout: no poll_done within %0d cycles", budget);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic        link;
        logic [1:0]  spd;
        logic        eth10;
        int          hold;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vec [NVEC];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pre;
        logic [13:0] exp_hdr;
        logic        prev_eth;
        int          cnt, n;

        // data, link_up, speed, eth_10mbps, adapter_rst-high cycles in 12 after S_EVAL
        vec[0]  = '{16'h4C00, 1'b0, 2'b01, 1'b0, 12};
        vec[1]  = '{16'h4C00, 1'b1, 2'b01, 1'b0, 8};
        vec[2]  = '{16'h4C00, 1'b1, 2'b01, 1'b0, 0};
        vec[3]  = '{16'h4800, 1'b1, 2'b01, 1'b0, 0};
        vec[4]  = '{16'h4C00, 1'b1, 2'b01, 1'b0, 0};
        vec[5]  = '{16'h4C00, 1'b1, 2'b01, 1'b0, 0};
        vec[6]  = '{16'h0C00, 1'b1, 2'b01, 1'b0, 0};
        vec[7]  = '{16'h0C00, 1'b1, 2'b00, 1'b1, 8};
        vec[8]  = '{16'h8C00, 1'b1, 2'b00, 1'b1, 0};
        vec[9]  = '{16'h8C00, 1'b0, 2'b00, 1'b1, 8};
        vec[10] = '{16'hFFFF, 1'b0, 2'b00, 1'b1, 0};
        vec[11] = '{16'hFFFF, 1'b0, 2'b00, 1'b1, 0};
        vec[12] = '{16'hFFFF, 1'b0, 2'b00, 1'b1, 0};
        vec[13] = '{16'h4C00, 1'b0, 2'b00, 1'b1, 0};
        vec[14] = '{16'h4C00, 1'b1, 2'b01, 1'b0, 8};

        exp_pre = 32'hFFFF_FFFF;
        exp_hdr = 14'b01_10_00011_10001;

        rst = 1'b1;
        phy_data = vec[0].data;
        repeat (3) @(negedge clk);
        check("rst_mdc",         32'(mdio_bus.mdc),     32'd0);
        check("rst_mdio_o",      32'(mdio_bus.mdio_o),  32'd1);
        check("rst_mdio_oe",     32'(mdio_bus.mdio_oe), 32'd0);
        check("rst_eth_10mbps",  32'(eth_10mbps),       32'd0);
        check("rst_adapter_rst", 32'(adapter_rst),      32'd1);
        check("rst_link_up",     32'(link_up),          32'd0);
        check("rst_speed",       32'(speed),            32'd1);
        check("rst_poll_done",   32'(poll_done),        32'd0);

        rst = 1'b0;
        @(posedge clk); #1;
        check("first_poll_start_oe", 32'(mdio_bus.mdio_oe), 32'd1);
        @(negedge clk);

        prev_eth = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            phy_data = vec[i].data;
            wait_poll(2000);
            if (i == 0) begin
                check("frame_oe_bits",    32'(tx_cnt),          32'd46);
                check("frame_preamble",   tx_bits[45:14],       exp_pre);
                check("frame_header",     32'(tx_bits[13:0]),   32'(exp_hdr));
                check("frame_ta_data_rises", 32'(rx_rise),      32'd18);
                check("frame_mdc_period", 32'(mdc_period),      32'd4);
            end
            check($sformatf("eval_arst_%0d", i), 32'(adapter_rst), (i < 2) ? 32'd1 : 32'd0);
            check($sformatf("eval_eth_%0d", i),  32'(eth_10mbps),  32'(prev_eth));
            @(negedge clk);
            check($sformatf("poll_done_pulse_%0d", i), 32'(poll_done), 32'd0);
            check($sformatf("link_up_%0d", i), 32'(link_up),    32'(vec[i].link));
            check($sformatf("speed_%0d", i),   32'(speed),      32'(vec[i].spd));
            check($sformatf("eth10_%0d", i),   32'(eth_10mbps), 32'(vec[i].eth10));
            cnt = 0;
            for (int k = 0; k < 12; k++) begin
                if (adapter_rst === 1'b1) cnt++;
                if (k < 11) @(negedge clk);
            end
            check($sformatf("arst_hold_%0d", i), 32'(cnt), 32'(vec[i].hold));
            prev_eth = vec[i].eth10;
        end

        // Asynchronous reset while the PHY is returning data, MDC high.
        n = 0;
        while (!(rx_rise >= 5 && rx_rise < 17 && mdio_bus.mdc === 1'b1) && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        check("reach_data_phase", 32'(n < 2000), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_mdc",         32'(mdio_bus.mdc),     32'd0);
        check("arst_mdio_oe",     32'(mdio_bus.mdio_oe), 32'd0);
        check("arst_adapter_rst", 32'(adapter_rst),      32'd1);
        check("arst_link_up",     32'(link_up),          32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("restart_oe", 32'(mdio_bus.mdio_oe), 32'd1);
        @(negedge clk);
        wait_poll(2000);
        check("restart_frame_bits", 32'(tx_cnt),  32'd46);
        @(negedge clk);
        check("restart_link_up",    32'(link_up),     32'd0);
        check("restart_adapter_rst", 32'(adapter_rst), 32'd1);

        check("mdio_o_high_when_released", 32'(o_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
